// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_arbiter
// Description : Two-master round-robin arbiter in front of the single-client
//               IO controller port (ADDR[31]=1 space). One outstanding
//               transaction at a time, with a per-transaction timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module io_bus_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RST,
  // master 0 (CPU load/store unit)
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_DIN,
  input  logic        M0_WE,
  input  logic        M0_RREQ,
  output logic [31:0] M0_DO,
  output logic        M0_RDY,
  // master 1 (debug/DMA)
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_DIN,
  input  logic        M1_WE,
  input  logic        M1_RREQ,
  output logic [31:0] M1_DO,
  output logic        M1_RDY,
  // slave (IO controller)
  output logic [31:0] S_ADDR,
  output logic [31:0] S_DIN,
  output logic        S_WE,
  output logic        S_RREQ,
  input  logic [31:0] S_DO,
  input  logic        S_RDY,
  // status
  output logic [1:0]  GRANT,
  output logic        TIMEOUT_ERR
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;       // 1 = master 1 was served last
  logic [31:0]   cmd_addr_q, cmd_addr_d;
  logic [31:0]   cmd_din_q, cmd_din_d;
  logic          cmd_we_q, cmd_we_d;
  logic          cmd_rd_q, cmd_rd_d;
  logic [31:0]   s_addr_q, s_addr_d;
  logic [31:0]   s_din_q, s_din_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   m0_do_q, m0_do_d;
  logic [31:0]   m1_do_q, m1_do_d;
  logic          tmo_err_q, tmo_err_d;

  logic          m0_req, m1_req, pick_m1;
  logic [CW-1:0] cnt_inc;
  logic [31:0]   resp_data;

  // Request decode, owner selection and next-state computation.
  always_comb begin
    m0_req     = M0_ADDR[31] & (M0_WE | M0_RREQ);
    m1_req     = M1_ADDR[31] & (M1_WE | M1_RREQ);
    // M1 wins when alone, or on a tie when M0 was served last.
    pick_m1    = m1_req & (~m0_req | ~last_q);
    cnt_inc    = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
    resp_data  = S_DO;

    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cmd_addr_d = cmd_addr_q;
    cmd_din_d  = cmd_din_q;
    cmd_we_d   = cmd_we_q;
    cmd_rd_d   = cmd_rd_q;
    s_addr_d   = s_addr_q;
    s_din_d    = s_din_q;
    cnt_d      = cnt_q;
    m0_do_d    = m0_do_q;
    m1_do_d    = m1_do_q;
    tmo_err_d  = tmo_err_q;

    case (state_q)
      ST_IDLE: begin
        if (m0_req | m1_req) begin
          grant_d    = pick_m1 ? 2'b10 : 2'b01;
          cmd_addr_d = pick_m1 ? M1_ADDR : M0_ADDR;
          cmd_din_d  = pick_m1 ? M1_DIN  : M0_DIN;
          // A write wins when both WE and RREQ are raised.
          cmd_we_d   = pick_m1 ? M1_WE : M0_WE;
          cmd_rd_d   = ~cmd_we_d;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        s_addr_d = cmd_addr_q;
        s_din_d  = cmd_din_q;
        cnt_d    = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (S_RDY || (cnt_inc == CW'(TIMEOUT))) begin
          if (!S_RDY) begin
            resp_data = ERR_DATA;
            tmo_err_d = 1'b1;
          end
          // Read data lands in the owner's register so it is valid with RDY.
          if (cmd_rd_q) begin
            if (grant_q[0]) m0_do_d = resp_data;
            if (grant_q[1]) m1_do_d = resp_data;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      grant_q    <= 2'b00;
      last_q     <= 1'b1;
      cmd_addr_q <= '0;
      cmd_din_q  <= '0;
      cmd_we_q   <= 1'b0;
      cmd_rd_q   <= 1'b0;
      s_addr_q   <= '0;
      s_din_q    <= '0;
      cnt_q      <= '0;
      m0_do_q    <= '0;
      m1_do_q    <= '0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_din_q  <= cmd_din_d;
      cmd_we_q   <= cmd_we_d;
      cmd_rd_q   <= cmd_rd_d;
      s_addr_q   <= s_addr_d;
      s_din_q    <= s_din_d;
      cnt_q      <= cnt_d;
      m0_do_q    <= m0_do_d;
      m1_do_q    <= m1_do_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  // Slave strobes drop combinationally on S_RDY so the slave never re-triggers.
  always_comb begin
    S_WE   = cmd_we_q & (state_q == ST_WAIT) & ~S_RDY;
    S_RREQ = cmd_rd_q & (state_q == ST_WAIT) & ~S_RDY;
  end

  assign S_ADDR      = s_addr_q;
  assign S_DIN       = s_din_q;
  assign GRANT       = grant_q;
  assign TIMEOUT_ERR = tmo_err_q;
  assign M0_DO       = m0_do_q;
  assign M1_DO       = m1_do_q;
  assign M0_RDY      = (state_q == ST_RESP) & grant_q[0];
  assign M1_RDY      = (state_q == ST_RESP) & grant_q[1];

endmodule
`default_nettype wire
